wiener_axis_output_stage: RTL and testbench



---
 rtl/wiener_axis_output_stage.sv | 168 ++++++++++++++++
 tb/tb_wiener_axis_output_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wiener_axis_output_stage.sv
// Output stage for the Wiener filter: tags pixels with frame position, buffers them in a
// first-word-fall-through FIFO and presents them as an AXI4-Stream video master.
module wiener_axis_output_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned AF_MARGIN  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [15:0]           frame_width_i,
    input  logic [15:0]           frame_height_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    input  logic                  in_sof_i,
    output logic                  almost_full_o,
    output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic                  m_axis_tuser_o,
    output logic                  m_axis_tlast_o,
    output logic                  frame_done_o,
    output logic [15:0]           frame_count_o,
    output logic                  overflow_o,
    output logic                  sync_err_o,
    input  logic                  clear_err_i
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = DATA_WIDTH + 3;
    localparam logic [CW-1:0] FullCount = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AfThresh  = CW'(FIFO_DEPTH - AF_MARGIN);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e        state_q, state_d;
    logic [15:0]   x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          af_q, fd_q, ovf_q, serr_q;
    logic [15:0]   fc_q;

    logic          wr_req, sync_set, tag_sof, tag_eol, tag_eof;
    logic          full, empty, push, pop;
    logic [EW-1:0] head;

    // Write-side framing; a sof in StStream restarts the frame exactly as from StIdle.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        w_d      = w_q;
        h_d      = h_q;
        wr_req   = 1'b0;
        sync_set = 1'b0;
        tag_sof  = 1'b0;
        tag_eol  = 1'b0;
        tag_eof  = 1'b0;
        if (in_valid_i) begin
            if (in_sof_i) begin
                if (state_q == StStream) sync_set = 1'b1;
                if (frame_width_i == 16'd0 || frame_height_i == 16'd0) begin
                    sync_set = 1'b1;
                    state_d  = StIdle;
                end else begin
                    w_d     = frame_width_i;
                    h_d     = frame_height_i;
                    wr_req  = 1'b1;
                    tag_sof = 1'b1;
                    tag_eol = (frame_width_i == 16'd1);
                    tag_eof = tag_eol && (frame_height_i == 16'd1);
                    x_d     = tag_eol ? 16'd0 : 16'd1;
                    y_d     = tag_eol ? 16'd1 : 16'd0;
                end
            end else if (state_q == StStream) begin
                wr_req  = 1'b1;
                tag_eol = (x_q == w_q - 16'd1);
                tag_eof = tag_eol && (y_q == h_q - 16'd1);
                x_d     = tag_eol ? 16'd0 : x_q + 16'd1;
                y_d     = tag_eol ? y_q + 16'd1 : y_q;
            end else begin
                sync_set = 1'b1;
            end
            if (wr_req) begin
                if (tag_eof) begin
                    state_d = StIdle;
                    x_d     = 16'd0;
                    y_d     = 16'd0;
                end else begin
                    state_d = StStream;
                end
            end
        end
    end

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);
    // A write while full is dropped even if a pop frees a slot in the same cycle.
    assign push  = wr_req & ~full;
    assign pop   = ~empty & m_axis_tready_i;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {tag_eof, tag_eol, tag_sof, in_data_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            af_q     <= 1'b0;
            fd_q     <= 1'b0;
            fc_q     <= '0;
            ovf_q    <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            af_q <= (count_q >= AfThresh);
            fd_q <= pop & head[EW-1];
            if (pop && head[EW-1]) fc_q <= fc_q + 16'd1;
            // New error events win over a simultaneous clear.
            if (wr_req && full) begin
                ovf_q <= 1'b1;
            end else if (clear_err_i) begin
                ovf_q <= 1'b0;
            end
            if (sync_set) begin
                serr_q <= 1'b1;
            end else if (clear_err_i) begin
                serr_q <= 1'b0;
            end
        end
    end

    assign m_axis_tvalid_o = ~empty;
    assign m_axis_tdata_o  = empty ? '0 : head[DATA_WIDTH-1:0];
    assign m_axis_tuser_o  = ~empty & head[DATA_WIDTH];
    assign m_axis_tlast_o  = ~empty & head[DATA_WIDTH+1];
    assign almost_full_o   = af_q;
    assign frame_done_o    = fd_q;
    assign frame_count_o   = fc_q;
    assign overflow_o      = ovf_q;
    assign sync_err_o      = serr_q;

endmodule

// File: tb/tb_wiener_axis_output_stage.sv
// Self-checking bench for wiener_axis_output_stage: directed scenarios plus a randomized run
// checked against a queue-based reference model.
module tb_wiener_axis_output_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] frame_width = 16'd0, frame_height = 16'd0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0, in_sof = 1'b0, tready = 1'b0, clear_err = 1'b0;
    logic        almost_full, m_axis_tvalid, m_axis_tuser, m_axis_tlast;
    logic        frame_done, overflow, sync_err;
    logic [31:0] m_axis_tdata;
    logic [15:0] frame_count;

    int checks = 0;
    int errors = 0;

    wiener_axis_output_stage dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .frame_width_i  (frame_width),
        .frame_height_i (frame_height),
        .in_data_i      (in_data),
        .in_valid_i     (in_valid),
        .in_sof_i       (in_sof),
        .almost_full_o  (almost_full),
        .m_axis_tdata_o (m_axis_tdata),
        .m_axis_tvalid_o(m_axis_tvalid),
        .m_axis_tready_i(tready),
        .m_axis_tuser_o (m_axis_tuser),
        .m_axis_tlast_o (m_axis_tlast),
        .frame_done_o   (frame_done),
        .frame_count_o  (frame_count),
        .overflow_o     (overflow),
        .sync_err_o     (sync_err),
        .clear_err_i    (clear_err)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is a run of w*h pixels counted from its sof pixel.
    typedef struct packed {
        logic [31:0] d;
        logic        u;
        logic        l;
        logic        e;
    } beat_t;

    beat_t       mq[$];
    bit          m_act = 1'b0;
    longint      m_k = 0, m_w = 1, m_h = 1;
    logic [15:0] m_fc = '0;
    bit          m_ovf = 1'b0, m_serr = 1'b0, m_fd = 1'b0, m_af = 1'b0;

    always @(posedge clk) begin
        beat_t b;
        bit    pop, full, wr, se, oe;
        if (rst) begin
            mq.delete();
            m_act = 1'b0; m_k = 0; m_fc = '0;
            m_ovf = 1'b0; m_serr = 1'b0; m_fd = 1'b0; m_af = 1'b0;
        end else begin
            pop  = (mq.size() > 0) && tready;
            full = (mq.size() == 16);
            m_af = (mq.size() >= 12);
            m_fd = pop && mq[0].e;
            if (m_fd) m_fc = m_fc + 16'd1;
            wr = 1'b0; se = 1'b0; oe = 1'b0;
            b = '0;
            if (in_valid) begin
                if (in_sof) begin
                    if (m_act) se = 1'b1;
                    if (frame_width == 0 || frame_height == 0) begin
                        se = 1'b1;
                        m_act = 1'b0;
                    end else begin
                        m_w = frame_width; m_h = frame_height; m_k = 0;
                        m_act = 1'b1; wr = 1'b1;
                    end
                end else if (m_act) begin
                    wr = 1'b1;
                end else begin
                    se = 1'b1;
                end
            end
            if (wr) begin
                b.d = in_data;
                b.u = (m_k == 0);
                b.l = ((m_k + 1) % m_w == 0);
                b.e = (m_k + 1 == m_w * m_h);
                m_k++;
                if (b.e) m_act = 1'b0;
                if (full) oe = 1'b1;
            end
            if (pop) void'(mq.pop_front());
            if (wr && !full) mq.push_back(b);
            m_ovf = oe ? 1'b1 : (clear_err ? 1'b0 : m_ovf);
            m_serr = se ? 1'b1 : (clear_err ? 1'b0 : m_serr);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timed out");
    end

    task automatic cyc(input bit v, input bit s, input logic [31:0] d, input bit r);
        in_valid = v; in_sof = s; in_data = d; tready = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(0, 0, '0, 0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(0, 0, '0, 1);
        cyc(0, 0, '0, 1);
        rst = 1'b0;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b want 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 32'd0) begin errors++; $display("FAIL rst_tdata: got %h want 0", m_axis_tdata); end
        checks++; if (m_axis_tuser !== 1'b0) begin errors++; $display("FAIL rst_tuser: got %b want 0", m_axis_tuser); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b want 0", m_axis_tlast); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fdone: got %b want 0", frame_done); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rst_fcount: got %0d want 0", frame_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL rst_serr: got %b want 0", sync_err); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL rst_af: got %b want 0", almost_full); end
    endtask

    task automatic test_basic();
        logic [31:0] px[8];
        int fd_cnt = 0;
        frame_width = 16'd4; frame_height = 16'd2;
        for (int i = 0; i < 8; i++) begin
            px[i] = $urandom;
            cyc(1, i == 0, px[i], 1);
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== px[i]) begin errors++; $display("FAIL basic_data[%0d]: got v=%b %h want v=1 %h", i, m_axis_tvalid, m_axis_tdata, px[i]); end
            checks++; if (m_axis_tuser !== (i == 0)) begin errors++; $display("FAIL basic_tuser[%0d]: got %b want %b", i, m_axis_tuser, i == 0); end
            checks++; if (m_axis_tlast !== (i == 3 || i == 7)) begin errors++; $display("FAIL basic_tlast[%0d]: got %b want %b", i, m_axis_tlast, i == 3 || i == 7); end
            fd_cnt += int'(frame_done);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, '0, 1);
            fd_cnt += int'(frame_done);
        end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL basic_fdone_count: got %0d want 1", fd_cnt); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL basic_fcount: got %0d want 1", frame_count); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] hold_d = '0;
        bit hold_v = 1'b0;
        bit r;
        int n = 0;
        frame_width = 16'd4; frame_height = 16'd2;
        for (int c = 0; c < 40; c++) begin
            r = (c % 3 == 0);
            if (n < 8) begin
                cyc(1, n == 0, $urandom, r);
                n++;
            end else begin
                cyc(0, 0, '0, r);
            end
            if (hold_v && !r) begin
                checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold_d) begin errors++; $display("FAIL bp_stable: got v=%b %h want v=1 %h", m_axis_tvalid, m_axis_tdata, hold_d); end
            end
            checks++; if (m_axis_tvalid !== (mq.size() > 0)) begin errors++; $display("FAIL bp_tvalid: got %b want %b", m_axis_tvalid, mq.size() > 0); end
            if (mq.size() > 0) begin
                checks++; if ({m_axis_tdata, m_axis_tuser, m_axis_tlast} !== {mq[0].d, mq[0].u, mq[0].l}) begin errors++; $display("FAIL bp_beat: got %h/%b/%b want %h/%b/%b", m_axis_tdata, m_axis_tuser, m_axis_tlast, mq[0].d, mq[0].u, mq[0].l); end
            end
            checks++; if (almost_full !== m_af) begin errors++; $display("FAIL bp_af: got %b want %b", almost_full, m_af); end
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_ovf: got %b want 0", overflow); end
            hold_v = m_axis_tvalid;
            hold_d = m_axis_tdata;
        end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL bp_fcount: got %0d want 2", frame_count); end
    endtask

    task automatic test_overflow();
        logic [31:0] px[20];
        int n = 0;
        do_reset();
        frame_width = 16'd8; frame_height = 16'd4;
        for (int i = 0; i < 20; i++) begin
            px[i] = $urandom;
            cyc(1, i == 0, px[i], 0);
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL ovf_af: got %b want 1", almost_full); end
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL ovf_serr: got %b want 0", sync_err); end
        for (int c = 0; c < 40 && m_axis_tvalid === 1'b1; c++) begin
            checks++; if (n >= 16 || m_axis_tdata !== px[n]) begin errors++; $display("FAIL ovf_data[%0d]: got %h want %h", n, m_axis_tdata, px[n % 20]); end
            checks++; if (m_axis_tlast !== (n == 7 || n == 15) || m_axis_tuser !== (n == 0)) begin errors++; $display("FAIL ovf_tags[%0d]: got l=%b u=%b want l=%b u=%b", n, m_axis_tlast, m_axis_tuser, n == 7 || n == 15, n == 0); end
            n++;
            cyc(0, 0, '0, 1);
        end
        checks++; if (n != 16) begin errors++; $display("FAIL ovf_beats: got %0d want 16", n); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b want 0", m_axis_tvalid); end
    endtask

    task automatic test_resync();
        logic [31:0] px[10];
        int fd_cnt = 0;
        do_reset();
        frame_width = 16'd4; frame_height = 16'd2;
        for (int i = 0; i < 10; i++) begin
            px[i] = $urandom;
            cyc(1, i == 0 || i == 2, px[i], 1);
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== px[i]) begin errors++; $display("FAIL resync_data[%0d]: got v=%b %h want v=1 %h", i, m_axis_tvalid, m_axis_tdata, px[i]); end
            checks++; if (m_axis_tuser !== (i == 0 || i == 2) || m_axis_tlast !== (i == 5 || i == 9)) begin errors++; $display("FAIL resync_tags[%0d]: got u=%b l=%b want u=%b l=%b", i, m_axis_tuser, m_axis_tlast, i == 0 || i == 2, i == 5 || i == 9); end
            fd_cnt += int'(frame_done);
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, '0, 1);
            fd_cnt += int'(frame_done);
        end
        checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL resync_serr: got %b want 1", sync_err); end
        checks++; if (fd_cnt != 1) begin errors++; $display("FAIL resync_fdone: got %0d want 1", fd_cnt); end
        checks++; if (frame_count !== 16'd1) begin errors++; $display("FAIL resync_fcount: got %0d want 1", frame_count); end
    endtask

    task automatic test_reset_mid();
        frame_width = 16'd4; frame_height = 16'd2;
        for (int i = 0; i < 5; i++) cyc(1, i == 0, $urandom, 0);
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL rmid_pre: got %b want 1", m_axis_tvalid); end
        rst = 1'b1;
        cyc(0, 0, '0, 0);
        rst = 1'b0;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid: got %b want 0", m_axis_tvalid); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL rmid_fcount: got %0d want 0", frame_count); end
        checks++; if (overflow !== 1'b0 || sync_err !== 1'b0) begin errors++; $display("FAIL rmid_flags: got %b%b want 00", overflow, sync_err); end
        frame_width = 16'd2; frame_height = 16'd2;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] d;
            d = $urandom;
            cyc(1, i == 0, d, 1);
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d || m_axis_tuser !== (i == 0) || m_axis_tlast !== (i == 1 || i == 3)) begin errors++; $display("FAIL rmid_beat[%0d]: got v=%b %h u=%b l=%b want v=1 %h u=%b l=%b", i, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, d, i == 0, i == 1 || i == 3); end
        end
        cyc(0, 0, '0, 1);
        checks++; if (frame_done !== 1'b1 || frame_count !== 16'd1) begin errors++; $display("FAIL rmid_done: got fd=%b fc=%0d want fd=1 fc=1", frame_done, frame_count); end
        cyc(0, 0, '0, 1);
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rmid_pulse: got %b want 0", frame_done); end
    endtask

    task automatic test_stray_zero();
        do_reset();
        frame_width = 16'd4; frame_height = 16'd2;
        cyc(1, 0, $urandom, 1);
        checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL stray_serr: got %b want 1", sync_err); end
        clear_err = 1'b1;
        cyc(1, 0, $urandom, 1);
        checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL stray_clr_prio: got %b want 1", sync_err); end
        cyc(0, 0, '0, 1);
        clear_err = 1'b0;
        checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL stray_clear: got %b want 0", sync_err); end
        frame_width = 16'd0;
        cyc(1, 1, $urandom, 1);
        checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL zero_serr: got %b want 1", sync_err); end
        cyc(1, 0, $urandom, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, '0, 1);
            checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL zero_tvalid: got %b want 0", m_axis_tvalid); end
        end
        clear_err = 1'b1;
        cyc(0, 0, '0, 1);
        clear_err = 1'b0;
        checks++; if (sync_err !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL zero_clear: got %b%b want 00", sync_err, overflow); end
    endtask

    typedef struct {
        bit          v;
        bit          s;
        logic [31:0] d;
        bit          r;
        logic [15:0] w;
        logic [15:0] h;
    } stim_t;

    task automatic test_random();
        stim_t st[$];
        stim_t e;
        do_reset();
        for (int f = 0; f < 30; f++) begin
            int w, h, len, bias, p;
            w = $urandom_range(1, 5);
            h = $urandom_range(1, 4);
            len = w * h;
            if ($urandom_range(0, 7) == 0) len = $urandom_range(1, len);
            bias = $urandom_range(10, 95);
            p = 0;
            while (p < len) begin
                e.v = ($urandom_range(0, 3) != 0);
                e.s = e.v && (p == 0);
                e.d = $urandom;
                e.r = ($urandom_range(0, 99) < bias);
                e.w = 16'(w);
                e.h = 16'(h);
                st.push_back(e);
                if (e.v) p++;
            end
        end
        for (int i = 0; i < 40; i++) begin
            e.v = 1'b0; e.s = 1'b0; e.d = '0; e.r = 1'b1;
            st.push_back(e);
        end
        for (int i = 0; i < st.size(); i++) begin
            frame_width = st[i].w;
            frame_height = st[i].h;
            cyc(st[i].v, st[i].s, st[i].d, st[i].r);
            checks++; if (m_axis_tvalid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_tvalid@%0d: got %b want %b", i, m_axis_tvalid, mq.size() > 0); end
            if (mq.size() > 0) begin
                checks++; if ({m_axis_tdata, m_axis_tuser, m_axis_tlast} !== {mq[0].d, mq[0].u, mq[0].l}) begin errors++; $display("FAIL rnd_beat@%0d: got %h/%b/%b want %h/%b/%b", i, m_axis_tdata, m_axis_tuser, m_axis_tlast, mq[0].d, mq[0].u, mq[0].l); end
            end
            checks++; if (frame_done !== m_fd || frame_count !== m_fc) begin errors++; $display("FAIL rnd_frame@%0d: got fd=%b fc=%0d want fd=%b fc=%0d", i, frame_done, frame_count, m_fd, m_fc); end
            checks++; if (overflow !== m_ovf || sync_err !== m_serr) begin errors++; $display("FAIL rnd_flags@%0d: got ovf=%b serr=%b want ovf=%b serr=%b", i, overflow, sync_err, m_ovf, m_serr); end
            checks++; if (almost_full !== m_af) begin errors++; $display("FAIL rnd_af@%0d: got %b want %b", i, almost_full, m_af); end
        end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rnd_drained: got %b want 0", m_axis_tvalid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_resync();
        test_reset_mid();
        test_stray_zero();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
